// File: rtl/score_tracker.sv
// score_tracker
//   Turns hit/miss verdicts from the judgement stage into game state (score,
//   combo, best combo, life, game-over) and drives the HIT/MISS popup sprite.
//   Every output is a register; an accepted verdict shows up one Clk later.
//
// Ports
//   Clk           in   system clock, rising edge
//   Reset_n       in   synchronous active-low reset
//   frame_tick    in   one-Clk pulse per vertical sync
//   judge_valid   in   one-Clk pulse, verdict present
//   judge_hit     in   1 = hit, 0 = miss (when judge_valid)
//   score         out  [15:0] accumulated points, saturating
//   combo         out  [9:0]  consecutive hits since last miss/reset
//   max_combo     out  [9:0]  best combo since reset
//   life          out  [3:0]  remaining life
//   game_over     out         sticky, set when life reaches 0
//   popup_active  out         popup sprite enable
//   popup_id      out  [3:0]  8 = HIT, 9 = MISS
//   popup_x       out  [9:0]  popup position (0 when inactive)
//   popup_y       out  [9:0]  popup position (0 when inactive)
//
// Game FSM
//   state | meaning
//   PLAY  | verdicts are accepted
//   OVER  | life exhausted, verdicts ignored until reset
//
// Popup FSM
//   state | meaning
//   IDLE  | no popup on screen
//   SHOW  | popup visible, r_cnt frames left

module score_tracker #(
  parameter logic [15:0] BASE_PTS     = 16'd10,
  parameter logic [3:0]  LIFE_MAX     = 4'd8,
  parameter logic [5:0]  POPUP_FRAMES = 6'd30
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic        judge_valid,
  input  logic        judge_hit,
  output logic [15:0] score,
  output logic [9:0]  combo,
  output logic [9:0]  max_combo,
  output logic [3:0]  life,
  output logic        game_over,
  output logic        popup_active,
  output logic [3:0]  popup_id,
  output logic [9:0]  popup_x,
  output logic [9:0]  popup_y
);

  typedef enum logic {PLAY, OVER} game_t;
  typedef enum logic {IDLE, SHOW} popup_t;

  game_t       r_game;
  popup_t      r_popup;
  logic [5:0]  r_cnt;

  logic        w_accept;
  logic [9:0]  w_combo_inc;
  logic [1:0]  w_mult;
  logic [17:0] w_pts;
  logic [17:0] w_sum;
  logic [15:0] w_score_sat;
  logic [3:0]  w_life_inc;
  logic [3:0]  w_life_dec;

  assign w_accept    = judge_valid && (r_game == PLAY);
  assign w_combo_inc = (combo == 10'd1023) ? combo : combo + 10'd1;

  // Multiplier is chosen from the combo value after this hit.
  assign w_mult = (w_combo_inc < 10'd10) ? 2'd1 :
                  (w_combo_inc < 10'd50) ? 2'd2 : 2'd3;

  // 18 bits hold BASE_PTS*3 plus a full 16-bit score without wrapping.
  assign w_pts       = {2'b00, BASE_PTS} * {16'd0, w_mult};
  assign w_sum       = {2'b00, score} + w_pts;
  assign w_score_sat = (w_sum[17:16] != 2'b00) ? 16'hFFFF : w_sum[15:0];

  assign w_life_inc = (life >= LIFE_MAX) ? LIFE_MAX : life + 4'd1;
  assign w_life_dec = life - 4'd1;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      score        <= 16'd0;
      combo        <= 10'd0;
      max_combo    <= 10'd0;
      life         <= LIFE_MAX;
      game_over    <= 1'b0;
      popup_active <= 1'b0;
      popup_id     <= 4'h0;
      popup_x      <= 10'd0;
      popup_y      <= 10'd0;
      r_game       <= PLAY;
      r_popup      <= IDLE;
      r_cnt        <= 6'd0;
    end else begin
      if (w_accept) begin
        if (judge_hit) begin
          combo <= w_combo_inc;
          score <= w_score_sat;
          life  <= w_life_inc;
          if (w_combo_inc > max_combo) max_combo <= w_combo_inc;
        end else begin
          combo <= 10'd0;
          life  <= w_life_dec;
          if (w_life_dec == 4'd0) begin
            game_over <= 1'b1;
            r_game    <= OVER;
          end
        end
        // A verdict reloads the popup even if a frame_tick lands on the same cycle.
        r_popup      <= SHOW;
        r_cnt        <= POPUP_FRAMES;
        popup_active <= 1'b1;
        popup_id     <= judge_hit ? 4'h8 : 4'h9;
        popup_x      <= 10'h140;
        popup_y      <= 10'h0F0;
      end else if (frame_tick && (r_popup == SHOW)) begin
        if (r_cnt == 6'd1) begin
          r_popup      <= IDLE;
          r_cnt        <= 6'd0;
          popup_active <= 1'b0;
          popup_id     <= 4'h0;
          popup_x      <= 10'd0;
          popup_y      <= 10'd0;
        end else begin
          r_cnt <= r_cnt - 6'd1;
        end
      end
    end
  end

endmodule

// File: doc/score_tracker.md
# score_tracker

Consumes the per-arrow hit/miss verdicts produced by the judgement stage and turns them into game state: running score, current combo, best combo, life gauge and game-over flag. It also owns the on-screen "HIT"/"MISS" popup sprite. It latches each verdict, holds the popup for a fixed number of video frames, then clears it. Outputs feed the sprite mux (popup ID/position) and the HUD digit renderer (score, combo, life).

## Interface
Parameters:
- BASE_PTS, 16'd10, points awarded per hit before the multiplier
- LIFE_MAX, 4'd8, life gauge value after reset; also the ceiling
- POPUP_FRAMES, 6'd30, number of frame ticks a popup stays visible (1..63)

Ports:
- Clk  in  1  system clock; all state is updated on its rising edge
- Reset_n  in  1  synchronous, active-low reset
- frame_tick  in  1  one-Clk pulse per vertical sync
- judge_valid  in  1  one-Clk pulse; a verdict is present this cycle
- judge_hit  in  1  verdict when judge_valid=1: 1 = hit, 0 = miss
- score  out  16  accumulated points, binary
- combo  out  10  consecutive hits since the last miss or reset
- max_combo  out  10  highest combo reached since reset
- life  out  4  remaining life
- game_over  out  1  sticky; set when life reaches 0
- popup_active  out  1  popup sprite enabled
- popup_id  out  4  4'h8 = hit, 4'h9 = miss
- popup_x  out  10  constant 10'h140 while active, 0 otherwise
- popup_y  out  10  constant 10'hF0 while active, 0 otherwise

## Operation
- Reset (Reset_n=0 at a Clk edge) sets the following and overrides all other inputs that cycle:
  - score=0, combo=0, max_combo=0, life=LIFE_MAX, game_over=0
  - popup_active=0, popup_id=0, popup_x=0, popup_y=0
  - game FSM=PLAY, popup FSM=IDLE, popup counter=0
- Game FSM:
  - In PLAY, a verdict (judge_valid=1) is accepted.
  - In OVER, all verdicts are ignored. Only reset leaves OVER.
- Accepted hit:
  - c' = combo+1, saturating at 1023.
  - Multiplier m: 1 if c'<10; 2 if 10 ≤ c' ≤ 49; 3 if c' ≥ 50.
  - score += BASE_PTS·m, computed at 18 bits and saturated to 16'hFFFF.
  - max_combo = max(max_combo, c').
  - life += 1, saturating at LIFE_MAX.
- Accepted miss:
  - combo=0; score and max_combo are unchanged.
  - life -= 1. If the result is 0, game_over=1 and the FSM goes to OVER in the same update.
  - A miss at life=0 cannot occur, because the FSM is already in OVER.
- Popup FSM (IDLE, SHOW):
  - Any accepted verdict, from either state, gives popup_active=1, popup_id = 8 (hit) or 9 (miss), position constants, counter=POPUP_FRAMES, and state SHOW.
  - In SHOW, each frame_tick decrements the counter.
  - A frame_tick that finds the counter at 1 returns the FSM to IDLE and clears the popup outputs.
  - The miss that causes game over still produces a MISS popup. That popup runs its full length in OVER.
- Simultaneous judge_valid and frame_tick: the verdict load wins and the counter is set to POPUP_FRAMES; that tick is not counted.

## Timing
- Every output is a register. An accepted verdict is visible on all outputs the Clk edge after the judge_valid cycle: 1-cycle latency, with no internal back-pressure.
- Verdicts on back-to-back cycles are each processed. The second verdict sees the already-updated combo and life.
- With no new verdict, the popup is visible for exactly POPUP_FRAMES frame_ticks after it loads. It clears on the edge that samples the POPUP_FRAMES-th tick.
- frame_tick and judge_valid are each treated as exactly one Clk wide. A level held high is counted once per cycle; that is the upstream's responsibility.

## Test plan
- Reset state: hold Reset_n=0 for 2 cycles, then release -> score=0, combo=0, max_combo=0, life=8, game_over=0, popup_active=0, popup_id=0.
- Multiplier and miss (defaults): 12 hits, one per 4 cycles -> score=150 (9×10 + 3×20), combo=12, max_combo=12, life=8. Then 1 miss -> combo=0, max_combo=12, score=150, life=7, popup_id=9.
- Popup lifetime: 1 hit, then 29 frame_ticks -> popup_active=1, id=8, x=10'h140, y=10'hF0. The 30th tick -> popup_active=0, x=y=0. A miss coinciding with a tick mid-popup -> counter reloads to 30 and id=9.
- Game over: 8 consecutive misses from reset -> life=0 and game_over=1 one cycle after the 8th. A further hit -> score, combo and life are unchanged, and the popup does not change to id 8.
- Score saturation: BASE_PTS=16'h4000, 5 hits -> score goes 4000, 8000, C000, FFFF, FFFF (hex).
- Reset mid-operation: assert Reset_n=0 while combo=5 and a popup is in SHOW, coincident with judge_valid=1 -> all reset values next cycle, and the verdict is dropped.
